counter_sweep_ctrl: RTL

//  Sequencer for the 8-bit loadable up/down counter (ld_en/updwn/en/datain -> dataout).

---
 rtl/sweep_pkg.sv | 18 +
 rtl/counter_sweep_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/sweep_pkg.sv
// Shared types and default widths for the counter sweep sequencer.
package sweep_pkg;
   localparam int CNT_W_DEF = 8;
   localparam int SWP_W_DEF = 8;

   typedef enum logic [1:0] {
      MODE_UP     = 2'd0,
      MODE_DOWN   = 2'd1,
      MODE_BOUNCE = 2'd2
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_e;
endpackage

// File: rtl/counter_sweep_ctrl.sv
// Sweep sequencer: takes a (lo, hi, mode, sweeps) config, loads an external
// up/down counter and steers it between the bounds until the sweep count is
// exhausted or the run is aborted. RUN-state counter controls are combinational
// so endpoints are handled without a dwell cycle.
module counter_sweep_ctrl
   import sweep_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int SWP_W = SWP_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CNT_W-1:0] cfg_lo,
   input  logic [CNT_W-1:0] cfg_hi,
   input  logic [1:0]       cfg_mode,
   input  logic [SWP_W-1:0] cfg_sweeps,
   input  logic             hold,
   input  logic             abort,
   input  logic [CNT_W-1:0] cnt_value,
   output logic             cnt_ld_en,
   output logic [CNT_W-1:0] cnt_datain,
   output logic             cnt_en,
   output logic             cnt_updwn,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic             err
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] lo_q, hi_q;
   logic [1:0]       mode_q;
   logic [SWP_W-1:0] rem_q, rem_d;
   logic             dir_q, dir_d;
   logic             abt_q, abt_d;
   logic             err_q, err_d;
   logic             accept, bad, endpoint;

   assign cfg_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign aborted   = done & abt_q;
   assign err       = err_q;

   // Next-state, sweep bookkeeping and counter controls
   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      dir_d      = dir_q;
      abt_d      = abt_q;
      err_d      = 1'b0;
      cnt_ld_en  = 1'b0;
      cnt_en     = 1'b0;
      cnt_updwn  = dir_q;
      cnt_datain = '0;
      accept     = 1'b0;
      bad        = (cfg_lo > cfg_hi) || (cfg_sweeps == '0) || (cfg_mode == 2'd3);
      endpoint   = dir_q ? (cnt_value == hi_q) : (cnt_value == lo_q);
      case (state_q)
         ST_IDLE: begin
            accept = cfg_valid;
            if (accept) begin
               rem_d = cfg_sweeps;
               abt_d = 1'b0;
               err_d = bad;
               if (!bad) state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            dir_d      = (mode_q != MODE_DOWN);
            cnt_datain = (mode_q == MODE_DOWN) ? hi_q : lo_q;
            if (abort) begin
               abt_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               cnt_ld_en = 1'b1;
               state_d   = ST_RUN;
            end
         end
         ST_RUN: begin
            if (abort) begin
               abt_d   = 1'b1;
               state_d = ST_DONE;
            end else if (!hold) begin
               if (!endpoint) begin
                  cnt_en = 1'b1;
               end else begin
                  rem_d = rem_q - 1'b1;
                  if (rem_q == SWP_W'(1)) begin
                     state_d = ST_DONE;
                  end else if (lo_q != hi_q) begin
                     // degenerate lo==hi range stays in RUN: one sweep per cycle
                     if (mode_q == MODE_BOUNCE) begin
                        dir_d     = !dir_q;
                        cnt_en    = 1'b1;
                        cnt_updwn = !dir_q;
                     end else begin
                        state_d = ST_LOAD;
                     end
                  end
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State, config latch and run bookkeeping registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         lo_q    <= '0;
         hi_q    <= '0;
         mode_q  <= 2'd0;
         rem_q   <= '0;
         dir_q   <= 1'b1;
         abt_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         dir_q   <= dir_d;
         abt_q   <= abt_d;
         err_q   <= err_d;
         if (accept) begin
            lo_q   <= cfg_lo;
            hi_q   <= cfg_hi;
            mode_q <= cfg_mode;
         end
      end
   end

endmodule
